decode_stage: RTL and testbench

//  Registered, parametrised ID stage. Decodes fetched instructions into rv32i_ctrl_word and buffers

---
 rtl/decode_stage_pkg.sv | 65 ++++++
 rtl/decode_stage_if.sv | 25 ++
 rtl/decode_rom.sv | 157 +++++++++++++++
 rtl/decode_stage.sv | 88 ++++++++
 tb/tb_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - RV32I decode types, control word and shared helpers
package decode_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  // Encodings line up with funct3 for add/sll/xor/srl/or/and
  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    mul = 3'b000, mulh = 3'b001, mulhsu = 3'b010, mulhu = 3'b011,
    div = 3'b100, divu = 3'b101, rem    = 3'b110, remu  = 3'b111
  } m_funct3_t;

  typedef enum logic {alumux1_rs1, alumux1_pc} alumux1_sel_t;
  typedef enum logic [2:0] {i_imm, u_imm, b_imm, s_imm, j_imm, rs2_out} alumux2_sel_t;
  typedef enum logic [2:0] {rf_alu, rf_br_en, rf_u_imm, rf_load, rf_pc_plus4} regfilemux_sel_t;
  typedef enum logic {cmp_rs2, cmp_imm} cmpmux_sel_t;

  typedef struct packed {
    rv32i_opcode     opcode;
    alu_ops          aluop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    cmpmux_sel_t     cmpmux_sel;
    logic [2:0]      cmpop;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [4:0]      source_reg1;
    logic [4:0]      source_reg2;
    logic [4:0]      dest_reg;
    logic            use_rs1;
    logic            use_rs2;
    logic            mul_div;
    m_funct3_t       md_op;
    logic [XLEN-1:0] curr_pc;
    logic [XLEN-1:0] pc_plus4;
  } rv32i_ctrl_word;

  // True when the instruction actually reads register r (x0 never creates a dependency)
  function automatic logic reads_reg(input rv32i_ctrl_word c, input logic [4:0] r);
    return (r != 5'd0) &&
           ((c.use_rs1 && (c.source_reg1 == r)) || (c.use_rs2 && (c.source_reg2 == r)));
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshakes of the decode stage
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic            flush;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_valid;
  logic            id_ready;
  rv32i_ctrl_word  id_ctrl;
  logic            id_illegal;

  modport master (
    output flush, if_valid, if_instr, if_pc, id_ready,
    input  if_ready, id_valid, id_ctrl, id_illegal
  );

  modport slave (
    input  flush, if_valid, if_instr, if_pc, id_ready,
    output if_ready, id_valid, id_ctrl, id_illegal
  );

endinterface

// File: rtl/decode_rom.sv
// rtl/decode_rom.sv - combinational RV32I(+M) instruction decode into a control word
module decode_rom
  import decode_stage_pkg::*;
#(
  parameter bit ENABLE_M_EXT = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output rv32i_ctrl_word  ctrl,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  rv32i_ctrl_word raw;
  logic           bad;

  // Per-opcode field decode; unused source fields stay at zero
  always_comb begin
    raw          = '0;
    bad          = 1'b0;
    raw.opcode   = rv32i_opcode'(opcode);
    raw.funct3   = funct3;
    raw.curr_pc  = pc;
    raw.pc_plus4 = pc + XLEN'(4);
    case (opcode)
      op_lui: begin
        raw.dest_reg       = rd;
        raw.load_regfile   = 1'b1;
        raw.alumux2_sel    = u_imm;
        raw.regfilemux_sel = rf_u_imm;
      end
      op_auipc: begin
        raw.dest_reg       = rd;
        raw.load_regfile   = 1'b1;
        raw.alumux1_sel    = alumux1_pc;
        raw.alumux2_sel    = u_imm;
      end
      op_jal: begin
        raw.dest_reg       = rd;
        raw.load_regfile   = 1'b1;
        raw.alumux1_sel    = alumux1_pc;
        raw.alumux2_sel    = j_imm;
        raw.regfilemux_sel = rf_pc_plus4;
      end
      op_jalr: begin
        raw.dest_reg       = rd;
        raw.load_regfile   = 1'b1;
        raw.use_rs1        = 1'b1;
        raw.source_reg1    = rs1;
        raw.regfilemux_sel = rf_pc_plus4;
      end
      op_br: begin
        raw.use_rs1     = 1'b1;
        raw.use_rs2     = 1'b1;
        raw.source_reg1 = rs1;
        raw.source_reg2 = rs2;
        raw.alumux1_sel = alumux1_pc;
        raw.alumux2_sel = b_imm;
        raw.cmpop       = funct3;
      end
      op_load: begin
        raw.dest_reg       = rd;
        raw.load_regfile   = 1'b1;
        raw.use_rs1        = 1'b1;
        raw.source_reg1    = rs1;
        raw.mem_read       = 1'b1;
        raw.regfilemux_sel = rf_load;
        bad                = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      op_store: begin
        raw.use_rs1     = 1'b1;
        raw.use_rs2     = 1'b1;
        raw.source_reg1 = rs1;
        raw.source_reg2 = rs2;
        raw.alumux2_sel = s_imm;
        raw.mem_write   = 1'b1;
        bad             = (funct3 >= 3'd3);
      end
      op_imm: begin
        raw.dest_reg     = rd;
        raw.load_regfile = 1'b1;
        raw.use_rs1      = 1'b1;
        raw.source_reg1  = rs1;
        case (funct3)
          3'b010: begin
            raw.cmpop          = 3'b100;
            raw.cmpmux_sel     = cmp_imm;
            raw.regfilemux_sel = rf_br_en;
          end
          3'b011: begin
            raw.cmpop          = 3'b110;
            raw.cmpmux_sel     = cmp_imm;
            raw.regfilemux_sel = rf_br_en;
          end
          3'b101:  raw.aluop = funct7[5] ? alu_sra : alu_srl;
          default: raw.aluop = alu_ops'(funct3);
        endcase
      end
      op_reg: begin
        raw.dest_reg     = rd;
        raw.load_regfile = 1'b1;
        raw.use_rs1      = 1'b1;
        raw.use_rs2      = 1'b1;
        raw.source_reg1  = rs1;
        raw.source_reg2  = rs2;
        raw.alumux2_sel  = rs2_out;
        if (funct7 == FUNCT7_MEXT) begin
          raw.mul_div = 1'b1;
          raw.md_op   = m_funct3_t'(funct3);
          bad         = !ENABLE_M_EXT;
        end else if ((funct7 == 7'd0) || (funct7 == FUNCT7_ALT)) begin
          case (funct3)
            3'b010: begin
              raw.cmpop          = 3'b100;
              raw.regfilemux_sel = rf_br_en;
            end
            3'b011: begin
              raw.cmpop          = 3'b110;
              raw.regfilemux_sel = rf_br_en;
            end
            3'b000:  raw.aluop = (funct7 == FUNCT7_ALT) ? alu_sub : alu_add;
            3'b101:  raw.aluop = (funct7 == FUNCT7_ALT) ? alu_sra : alu_srl;
            default: raw.aluop = alu_ops'(funct3);
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
  end

  // Illegal words keep only their PCs so EX can trap; writes to x0 are suppressed
  always_comb begin
    ctrl    = raw;
    illegal = bad;
    if (bad) begin
      ctrl          = '0;
      ctrl.curr_pc  = pc;
      ctrl.pc_plus4 = pc + XLEN'(4);
    end else if (raw.dest_reg == 5'd0) begin
      ctrl.load_regfile = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered ID stage: decode ROM, output FIFO and load-use interlock
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int BUF_DEPTH      = 2,
  parameter int LOAD_USE_STALL = 1,
  parameter bit ENABLE_M_EXT   = 1'b1
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W   = 3;
  localparam int STALL_W = 4;

  rv32i_ctrl_word     rom_ctrl;
  logic               rom_illegal;
  rv32i_ctrl_word     ctrl_mem [BUF_DEPTH];
  logic               ill_mem  [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [STALL_W-1:0] stall_cnt;
  logic [4:0]         last_load_rd;
  rv32i_ctrl_word     head;
  logic               hazard, push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  decode_rom #(.ENABLE_M_EXT(ENABLE_M_EXT)) u_rom (
    .instr   (bus.if_instr),
    .pc      (bus.if_pc),
    .ctrl    (rom_ctrl),
    .illegal (rom_illegal)
  );

  assign head   = ctrl_mem[rd_ptr];
  assign hazard = (stall_cnt != '0) && reads_reg(head, last_load_rd);

  assign bus.id_valid   = !rst && !bus.flush && (count != '0) && !hazard;
  assign pop            = bus.id_valid && bus.id_ready;
  assign bus.if_ready   = !rst && !bus.flush && ((count < CNT_W'(BUF_DEPTH)) || pop);
  assign push           = bus.if_valid && bus.if_ready;
  assign bus.id_ctrl    = head;
  assign bus.id_illegal = ill_mem[rd_ptr];

  // FIFO storage: the decoded word is captured at the accept edge
  always_ff @(posedge clk) begin
    if (push) begin
      ctrl_mem[wr_ptr] <= rom_ctrl;
      ill_mem[wr_ptr]  <= rom_illegal;
    end
  end

  // Pointers, occupancy and load-use stall state; flush empties the FIFO ahead of any push
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      stall_cnt    <= '0;
      last_load_rd <= '0;
    end else if (bus.flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop && (head.opcode == op_load) && (head.dest_reg != 5'd0)) begin
        stall_cnt    <= STALL_W'(LOAD_USE_STALL);
        last_load_rd <= head.dest_reg;
      end else if (stall_cnt != '0) begin
        stall_cnt <= stall_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized and directed checks of decode_stage against a queue model
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int LUS = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage_if bus_nm ();

  decode_stage #(.BUF_DEPTH(2), .LOAD_USE_STALL(LUS), .ENABLE_M_EXT(1'b1)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  decode_stage #(.BUF_DEPTH(2), .LOAD_USE_STALL(LUS), .ENABLE_M_EXT(1'b0)) dut_nm (
    .clk (clk), .rst (rst), .bus (bus_nm)
  );

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    bit          use1, use2, wr, mr, mw, md, ill;
    logic [2:0]  mdop;
    logic [31:0] pc, pc4;
  } exp_t;

  exp_t        q[$];
  int          stall_left;
  logic [4:0]  last_rd;
  int          total, bad;

  logic           s_id_valid, s_if_ready, s_ill, s2_valid, s2_ill;
  rv32i_ctrl_word s_ctrl, s2_ctrl;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected decode from the ISA: which operands are read, whether rd is written, legality
  function automatic exp_t model_decode(input logic [31:0] instr, input logic [31:0] pc, input bit m_en);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit legal, wr;
    op = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
    e = '{default: 0};
    legal = 1; wr = 0;
    case (op)
      7'h37, 7'h17, 7'h6f: wr = 1;
      7'h67: begin wr = 1; e.use1 = 1; end
      7'h63: begin e.use1 = 1; e.use2 = 1; end
      7'h03: begin wr = 1; e.use1 = 1; e.mr = 1; legal = !(f3 == 3 || f3 == 6 || f3 == 7); end
      7'h23: begin e.use1 = 1; e.use2 = 1; e.mw = 1; legal = (f3 < 3); end
      7'h13: begin wr = 1; e.use1 = 1; end
      7'h33: begin
        wr = 1; e.use1 = 1; e.use2 = 1;
        if (f7 == 7'h01) begin legal = m_en; e.md = 1; e.mdop = f3; end
        else legal = (f7 == 7'h00 || f7 == 7'h20);
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      e = '{default: 0};
      e.ill = 1; e.pc = pc; e.pc4 = pc + 32'd4;
      return e;
    end
    e.op  = op;
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
    e.rd  = wr ? instr[11:7] : 5'd0;
    e.rs1 = e.use1 ? instr[19:15] : 5'd0;
    e.rs2 = e.use2 ? instr[24:20] : 5'd0;
    e.wr  = wr && (e.rd != 0);
    return e;
  endfunction

  function automatic bit model_dep(input exp_t e, input logic [4:0] r);
    return (r != 0) && ((e.use1 && e.rs1 == r) || (e.use2 && e.rs2 == r));
  endfunction

  task automatic compare_head(input exp_t e, input rv32i_ctrl_word c, input logic ill);
    rv32i_ctrl_word z;
    check_eq("opcode", c.opcode, e.op);
    check_eq("dest_reg", c.dest_reg, e.rd);
    check_eq("source_reg1", c.source_reg1, e.rs1);
    check_eq("source_reg2", c.source_reg2, e.rs2);
    check_eq("use_rs1", c.use_rs1, e.use1);
    check_eq("use_rs2", c.use_rs2, e.use2);
    check_eq("load_regfile", c.load_regfile, e.wr);
    check_eq("mem_read", c.mem_read, e.mr);
    check_eq("mem_write", c.mem_write, e.mw);
    check_eq("mul_div", c.mul_div, e.md);
    check_eq("md_op", c.md_op, e.mdop);
    check_eq("id_illegal", ill, e.ill);
    check_eq("curr_pc", c.curr_pc, e.pc);
    check_eq("pc_plus4", c.pc_plus4, e.pc4);
    if (e.ill) begin
      z = c; z.curr_pc = '0; z.pc_plus4 = '0;
      check_eq("ill_ctrl_zero", z == '0, 1'b1);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model at the next posedge
  task automatic run_cycle(input bit r, input bit v, input logic [31:0] ins, input logic [31:0] pc,
                           input bit rdy, input bit fl);
    bit exp_v, exp_r, acc, iss;
    exp_t hd, e_new;
    rst = r; bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc; bus.id_ready = rdy; bus.flush = fl;
    @(negedge clk);
    exp_v = !r && !fl && (q.size() > 0) && !(stall_left > 0 && model_dep(q[0], last_rd));
    exp_r = !r && !fl && ((q.size() < 2) || (exp_v && rdy));
    s_id_valid = bus.id_valid; s_if_ready = bus.if_ready; s_ctrl = bus.id_ctrl; s_ill = bus.id_illegal;
    s2_valid = bus_nm.id_valid; s2_ctrl = bus_nm.id_ctrl; s2_ill = bus_nm.id_illegal;
    check_eq("id_valid", bus.id_valid, exp_v);
    check_eq("if_ready", bus.if_ready, exp_r);
    if (!r && q.size() > 0) compare_head(q[0], bus.id_ctrl, bus.id_illegal);
    acc = v && exp_r;
    iss = exp_v && rdy;
    e_new = model_decode(ins, pc, 1'b1);
    @(posedge clk);
    if (r) begin
      q.delete(); stall_left = 0; last_rd = 0;
    end else if (fl) begin
      q.delete(); stall_left = 0;
    end else begin
      if (iss) hd = q.pop_front();
      if (acc) q.push_back(e_new);
      if (iss && hd.op == 7'h03 && hd.rd != 0) begin
        stall_left = LUS; last_rd = hd.rd;
      end else if (stall_left > 0) begin
        stall_left--;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    case ($urandom_range(0, 9))
      0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6f; 3: op = 7'h67; 4: op = 7'h63;
      5: op = 7'h03; 6: op = 7'h23; 7: op = 7'h13; 8: op = 7'h33;
      default: op = 7'($urandom);
    endcase
    rd = 5'($urandom_range(0, 3)); rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  localparam logic [31:0] ADDI5   = 32'h00500093;
  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_DEP = 32'h00228333;
  localparam logic [31:0] ADD_IND = 32'h00838333;
  localparam logic [31:0] LW_X0   = 32'h0000A003;

  initial begin
    total = 0; bad = 0; stall_left = 0; last_rd = 0;
    rst = 1; bus.flush = 0; bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.id_ready = 0;
    bus_nm.flush = 0; bus_nm.if_valid = 0; bus_nm.if_instr = 0; bus_nm.if_pc = 0; bus_nm.id_ready = 1;
    @(posedge clk); #1;

    // reset held with fetch presenting
    run_cycle(1, 1, ADDI5, 32'h100, 1, 0);
    check_eq("rst_if_ready", s_if_ready, 0);
    run_cycle(1, 1, ADDI5, 32'h100, 1, 0);
    check_eq("rst_id_valid", s_id_valid, 0);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("post_rst_if_ready", s_if_ready, 1);
    check_eq("post_rst_empty", s_id_valid, 0);

    // addi decode and PC wrap
    run_cycle(0, 1, ADDI5, 32'h100, 1, 0);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("addi_valid", s_id_valid, 1);
    check_eq("addi_opcode", s_ctrl.opcode, op_imm);
    check_eq("addi_load", s_ctrl.load_regfile, 1);
    check_eq("addi_use_rs2", s_ctrl.use_rs2, 0);
    check_eq("addi_rs2", s_ctrl.source_reg2, 0);
    check_eq("addi_pc4", s_ctrl.pc_plus4, 32'h104);
    run_cycle(0, 1, ADDI5, 32'hFFFF_FFFC, 1, 0);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("wrap_pc4", s_ctrl.pc_plus4, 32'h0);

    // fill with id_ready low, then drain with push+pop at full
    run_cycle(0, 1, 32'h00100093, 32'h10, 0, 0);
    run_cycle(0, 1, 32'h00200113, 32'h14, 0, 0);
    run_cycle(0, 1, 32'h00300193, 32'h18, 0, 0);
    check_eq("full_if_ready", s_if_ready, 0);
    run_cycle(0, 1, 32'h00300193, 32'h18, 1, 0);
    check_eq("full_pushpop_ready", s_if_ready, 1);
    check_eq("order_1", s_ctrl.dest_reg, 1);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("order_2", s_ctrl.dest_reg, 2);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("order_3", s_ctrl.dest_reg, 3);
    check_eq("order_3_valid", s_id_valid, 1);
    idle(2);

    // load-use interlock: one bubble for a dependent add, none otherwise
    run_cycle(0, 1, LW_X5, 32'h20, 1, 0);
    run_cycle(0, 1, ADD_DEP, 32'h24, 1, 0);
    check_eq("lw_issue", s_id_valid, 1);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("lu_bubble", s_id_valid, 0);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("lu_after_bubble", s_id_valid, 1);
    idle(2);
    run_cycle(0, 1, LW_X5, 32'h30, 1, 0);
    run_cycle(0, 1, ADD_IND, 32'h34, 1, 0);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("lu_indep", s_id_valid, 1);
    idle(2);
    run_cycle(0, 1, LW_X0, 32'h40, 1, 0);
    run_cycle(0, 1, ADD_DEP, 32'h44, 1, 0);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("lu_x0", s_id_valid, 1);
    idle(2);

    // M extension enabled vs disabled, and an unknown opcode
    bus_nm.if_valid = 1; bus_nm.if_instr = 32'h02208033; bus_nm.if_pc = 32'h200;
    run_cycle(0, 1, 32'h02208033, 32'h200, 1, 0);
    bus_nm.if_valid = 0;
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("mul_md", s_ctrl.mul_div, 1);
    check_eq("mul_op", s_ctrl.md_op, 0);
    check_eq("mul_rd0_load", s_ctrl.load_regfile, 0);
    check_eq("nm_valid", s2_valid, 1);
    check_eq("nm_illegal", s2_ill, 1);
    check_eq("nm_pc", s2_ctrl.curr_pc, 32'h200);
    check_eq("nm_pc4", s2_ctrl.pc_plus4, 32'h204);
    check_eq("nm_md", s2_ctrl.mul_div, 0);
    check_eq("nm_load", s2_ctrl.load_regfile, 0);
    run_cycle(0, 1, 32'h022080B3, 32'h204, 1, 0);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("mul_rd1_load", s_ctrl.load_regfile, 1);
    run_cycle(0, 1, 32'h0000007F, 32'h208, 1, 0);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("bad_opcode", s_ill, 1);
    idle(2);

    // flush with two entries buffered and the stall counter armed
    run_cycle(0, 1, LW_X5, 32'h50, 0, 0);
    run_cycle(0, 1, ADD_DEP, 32'h54, 0, 0);
    run_cycle(0, 1, 32'h00100093, 32'h58, 1, 0);
    run_cycle(0, 1, 32'h00100093, 32'h5C, 1, 1);
    check_eq("flush_if_ready", s_if_ready, 0);
    check_eq("flush_id_valid", s_id_valid, 0);
    run_cycle(0, 1, ADD_DEP, 32'h60, 1, 0);
    check_eq("post_flush_empty", s_id_valid, 0);
    run_cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check_eq("post_flush_issue", s_id_valid, 1);
    check_eq("post_flush_rd", s_ctrl.dest_reg, 6);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      run_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, rand_instr(), pc,
                $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
